// File: rtl/pool_flatten.sv
// pool_flatten: 2x2 stride-2 max-pool of L0 maps into L1 plus channel-interleaved flat copy into L2
// Ports:
//   clk                 rising-edge clock
//   reset               asynchronous active-low reset
//   start / busy / done pass handshake with the conv engine
//   crd, caddr_rd       read strobe / address; cdata_rd returns one cycle later
//   cwr, caddr_wr,      write strobe / address / data
//   cdata_wr
//   csel                memory select (1/2 L0, 3/4 L1, 5 L2)
module pool_flatten #(
    parameter int DW    = 20,
    parameter int IMG_W = 64,
    parameter int NCH   = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          crd,
    output logic [11:0]   caddr_rd,
    input  logic [DW-1:0] cdata_rd,
    output logic          cwr,
    output logic [11:0]   caddr_wr,
    output logic [DW-1:0] cdata_wr,
    output logic [2:0]    csel
);
    localparam int CW = $clog2(IMG_W / 2);
    localparam int PW = 2 * CW;

    typedef enum logic [3:0] {IDLE, RD0, RD1, RD2, RD3, CAP, WL1, WL2, DONE} state_t;

    state_t        st, st_n;
    logic [PW-1:0] p, p_n;
    logic          ch, ch_n;
    logic [DW-1:0] mx, mx_n, mx_up;
    logic          busy_n, done_n, crd_n, cwr_n, last;
    logic [11:0]   ard_n, awr_n;
    logic [DW-1:0] wd_n;
    logic [2:0]    csel_n;

    // top-left word of window p: row 2r, column 2c
    function automatic logic [11:0] base_of(input logic [PW-1:0] q);
        return 12'({q[PW-1:CW], 1'b0, q[CW-1:0], 1'b0});
    endfunction

    assign mx_up = (cdata_rd > mx) ? cdata_rd : mx;
    assign last  = (&p) && (NCH == 1 || ch);

    // outputs are registered, so each state computes the bus values of the state it enters
    always_comb begin
        st_n   = st;
        p_n    = p;
        ch_n   = ch;
        mx_n   = mx;
        busy_n = busy;
        done_n = 1'b0;
        crd_n  = 1'b0;
        cwr_n  = 1'b0;
        ard_n  = caddr_rd;
        awr_n  = caddr_wr;
        wd_n   = cdata_wr;
        csel_n = csel;
        case (st)
            IDLE: if (start) begin
                st_n   = RD0;
                busy_n = 1'b1;
                crd_n  = 1'b1;
                csel_n = 3'd1 + {2'b00, ch};
                ard_n  = base_of(p);
            end
            RD0: begin
                st_n  = RD1;
                crd_n = 1'b1;
                ard_n = base_of(p) + 12'd1;
            end
            RD1: begin
                st_n  = RD2;
                crd_n = 1'b1;
                ard_n = base_of(p) + 12'(IMG_W);
                mx_n  = cdata_rd;
            end
            RD2: begin
                st_n  = RD3;
                crd_n = 1'b1;
                ard_n = base_of(p) + 12'(IMG_W + 1);
                mx_n  = mx_up;
            end
            RD3: begin
                st_n = CAP;
                mx_n = mx_up;
            end
            CAP: begin
                st_n   = WL1;
                mx_n   = mx_up;
                cwr_n  = 1'b1;
                csel_n = 3'd3 + {2'b00, ch};
                awr_n  = 12'(p);
                wd_n   = mx_up;
            end
            WL1: begin
                st_n   = WL2;
                cwr_n  = 1'b1;
                csel_n = 3'd5;
                awr_n  = (NCH == 2) ? 12'({p, ch}) : 12'(p);
            end
            WL2: if (last) begin
                st_n   = DONE;
                csel_n = 3'd0;
            end else begin
                if (NCH == 2 && !ch)
                    ch_n = 1'b1;
                else begin
                    ch_n = 1'b0;
                    p_n  = p + 1'b1;
                end
                st_n   = RD0;
                crd_n  = 1'b1;
                csel_n = 3'd1 + {2'b00, ch_n};
                ard_n  = base_of(p_n);
            end
            DONE: begin
                st_n   = IDLE;
                busy_n = 1'b0;
                done_n = 1'b1;
                p_n    = '0;
                ch_n   = 1'b0;
            end
            default: st_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st       <= IDLE;
            p        <= '0;
            ch       <= 1'b0;
            mx       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            crd      <= 1'b0;
            cwr      <= 1'b0;
            caddr_rd <= '0;
            caddr_wr <= '0;
            cdata_wr <= '0;
            csel     <= '0;
        end else begin
            st       <= st_n;
            p        <= p_n;
            ch       <= ch_n;
            mx       <= mx_n;
            busy     <= busy_n;
            done     <= done_n;
            crd      <= crd_n;
            cwr      <= cwr_n;
            caddr_rd <= ard_n;
            caddr_wr <= awr_n;
            cdata_wr <= wd_n;
            csel     <= csel_n;
        end
    end
endmodule
